// File: rtl/eth_rgmii_rx.sv
// rtl/eth_rgmii_rx.sv - RGMII receive framer: preamble strip, FCS withholding, frame status
//
// eth_crc32_8: one byte step of the reflected Ethernet CRC-32 (poly 32'hEDB88320).
//   crc_i   in  32  current CRC register
//   data_i  in   8  byte to fold in (LSB first on the wire)
//   crc_o   out 32  updated CRC register
//
// eth_rgmii_rx: framer for the byte-wide rx_clk stream coming from the RX pin glue.
//   Strips preamble/SFD, holds back the trailing 4 FCS bytes through a 4-byte delay
//   line, checks FCS/length/rx_er and reports one status strobe per frame.
//   rx_clk     in   1   receive clock, the only clock
//   rst_n      in   1   asynchronous active-low reset
//   rx_dv      in   1   receive data valid
//   rx_er      in   1   receive error
//   rx_data    in   8   received byte
//   out_valid  out  1   out_data carries a frame data byte
//   out_sop    out  1   first data byte of the frame (qualifies out_valid)
//   out_data   out  8   frame data byte, DA through last payload byte
//   done       out  1   one-cycle pulse, status fields below are valid
//   ok         out  1   frame good
//   crc_bad    out  1   FCS mismatch
//   runt       out  1   length < MIN_LEN
//   giant      out  1   length > MAX_LEN
//   phy_err    out  1   rx_er seen during the frame
//   length     out  11  bytes received DA..FCS, saturating at MAX_LEN+1

module eth_crc32_8 (
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        crc_o = crc_i ^ {24'h0, data_i};
        for (int k = 0; k < 8; k++) begin
            crc_o = crc_o[0] ? ((crc_o >> 1) ^ 32'hEDB88320) : (crc_o >> 1);
        end
    end

endmodule

module eth_rgmii_rx #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        rx_clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rx_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic [7:0]  out_data,
    output logic        done,
    output logic        ok,
    output logic        crc_bad,
    output logic        runt,
    output logic        giant,
    output logic        phy_err,
    output logic [10:0] length
);

    localparam logic [10:0] MinLen      = 11'(MIN_LEN);
    localparam logic [10:0] MaxLen      = 11'(MAX_LEN);
    localparam logic [31:0] CrcSeed     = 32'hFFFFFFFF;
    // Register value left after running the CRC over data plus its own FCS.
    localparam logic [31:0] CrcResidue  = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, PRE, PKT, DROP} state_t;

    state_t      state_q, state_d;
    logic        from_pkt_q, from_pkt_d;
    logic [10:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] dl_q, dl_d;        // delay line, oldest byte in [31:24]
    logic [2:0]  dl_cnt_q, dl_cnt_d;
    logic        sop_pend_q, sop_pend_d;
    logic        frm_phy_q, frm_phy_d;
    logic        frm_giant_q, frm_giant_d;

    logic        out_valid_q, out_valid_d;
    logic        out_sop_q, out_sop_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        crc_bad_q, crc_bad_d;
    logic        runt_q, runt_d;
    logic        giant_q, giant_d;
    logic        phy_err_q, phy_err_d;
    logic [10:0] length_q, length_d;

    logic [31:0] crc_next;
    logic        end_frame;

    eth_crc32_8 u_crc (
        .crc_i  (crc_q),
        .data_i (rx_data),
        .crc_o  (crc_next)
    );

    always_comb begin
        state_d     = state_q;
        from_pkt_d  = from_pkt_q;
        len_d       = len_q;
        crc_d       = crc_q;
        dl_d        = dl_q;
        dl_cnt_d    = dl_cnt_q;
        sop_pend_d  = sop_pend_q;
        frm_phy_d   = frm_phy_q;
        frm_giant_d = frm_giant_q;
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        ok_d        = ok_q;
        crc_bad_d   = crc_bad_q;
        runt_d      = runt_q;
        giant_d     = giant_q;
        phy_err_d   = phy_err_q;
        length_d    = length_q;
        end_frame   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_dv) begin
                    if (rx_data == 8'h55) begin
                        state_d = PRE;
                    end else begin
                        state_d    = DROP;
                        from_pkt_d = 1'b0;
                    end
                end
            end
            PRE: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end else if (rx_data == 8'h55) begin
                    state_d = PRE;
                end else if (rx_data == 8'hD5) begin
                    state_d     = PKT;
                    len_d       = 11'd0;
                    crc_d       = CrcSeed;
                    dl_d        = 32'h0;
                    dl_cnt_d    = 3'd0;
                    sop_pend_d  = 1'b1;
                    frm_phy_d   = 1'b0;
                    frm_giant_d = 1'b0;
                end else begin
                    state_d    = DROP;
                    from_pkt_d = 1'b0;
                end
            end
            PKT: begin
                if (!rx_dv) begin
                    end_frame = 1'b1;
                    state_d   = IDLE;
                end else if (rx_er) begin
                    frm_phy_d  = 1'b1;
                    state_d    = DROP;
                    from_pkt_d = 1'b1;
                end else if (len_q >= MaxLen) begin
                    // This byte pushes the count past the maximum: count it, stop output.
                    len_d       = MaxLen + 11'd1;
                    frm_giant_d = 1'b1;
                    state_d     = DROP;
                    from_pkt_d  = 1'b1;
                end else begin
                    crc_d = crc_next;
                    len_d = len_q + 11'd1;
                    dl_d  = {dl_q[23:0], rx_data};
                    if (dl_cnt_q == 3'd4) begin
                        out_valid_d = 1'b1;
                        out_sop_d   = sop_pend_q;
                        out_data_d  = dl_q[31:24];
                        sop_pend_d  = 1'b0;
                    end else begin
                        dl_cnt_d = dl_cnt_q + 3'd1;
                    end
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    state_d   = IDLE;
                    end_frame = from_pkt_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (end_frame) begin
            done_d    = 1'b1;
            phy_err_d = frm_phy_q;
            giant_d   = frm_giant_q;
            crc_bad_d = !(frm_phy_q || frm_giant_q) && (crc_q != CrcResidue);
            runt_d    = (len_q < MinLen);
            ok_d      = !(crc_bad_d || runt_d || frm_giant_q || frm_phy_q);
            length_d  = len_q;
        end
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            from_pkt_q  <= 1'b0;
            len_q       <= 11'd0;
            crc_q       <= CrcSeed;
            dl_q        <= 32'h0;
            dl_cnt_q    <= 3'd0;
            sop_pend_q  <= 1'b0;
            frm_phy_q   <= 1'b0;
            frm_giant_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_data_q  <= 8'h0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            crc_bad_q   <= 1'b0;
            runt_q      <= 1'b0;
            giant_q     <= 1'b0;
            phy_err_q   <= 1'b0;
            length_q    <= 11'd0;
        end else begin
            state_q     <= state_d;
            from_pkt_q  <= from_pkt_d;
            len_q       <= len_d;
            crc_q       <= crc_d;
            dl_q        <= dl_d;
            dl_cnt_q    <= dl_cnt_d;
            sop_pend_q  <= sop_pend_d;
            frm_phy_q   <= frm_phy_d;
            frm_giant_q <= frm_giant_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            crc_bad_q   <= crc_bad_d;
            runt_q      <= runt_d;
            giant_q     <= giant_d;
            phy_err_q   <= phy_err_d;
            length_q    <= length_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign ok        = ok_q;
    assign crc_bad   = crc_bad_q;
    assign runt      = runt_q;
    assign giant     = giant_q;
    assign phy_err   = phy_err_q;
    assign length    = length_q;

endmodule

// File: tb/tb_eth_rgmii_rx.sv
// tb/tb_eth_rgmii_rx.sv - directed self-checking bench for eth_rgmii_rx

module tb_eth_rgmii_rx;

    logic        rx_clk = 1'b0;
    logic        rst_n;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  rx_data;
    logic        out_valid;
    logic        out_sop;
    logic [7:0]  out_data;
    logic        done;
    logic        ok;
    logic        crc_bad;
    logic        runt;
    logic        giant;
    logic        phy_err;
    logic [10:0] length;

    eth_rgmii_rx #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .rx_clk    (rx_clk),
        .rst_n     (rst_n),
        .rx_dv     (rx_dv),
        .rx_er     (rx_er),
        .rx_data   (rx_data),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_data  (out_data),
        .done      (done),
        .ok        (ok),
        .crc_bad   (crc_bad),
        .runt      (runt),
        .giant     (giant),
        .phy_err   (phy_err),
        .length    (length)
    );

    always #5 rx_clk = ~rx_clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  frm [0:2047];
    int          frm_len;
    logic [7:0]  got [$];
    logic        got_sop [$];
    int          done_cnt = 0;
    int          ok_cnt = 0;
    logic        l_ok, l_crc_bad, l_runt, l_giant, l_phy;
    logic [10:0] l_len;

    always @(negedge rx_clk) begin
        if (out_valid) begin
            got.push_back(out_data);
            got_sop.push_back(out_sop);
        end
        if (done) begin
            done_cnt++;
            if (ok) ok_cnt++;
            l_ok = ok; l_crc_bad = crc_bad; l_runt = runt;
            l_giant = giant; l_phy = phy_err; l_len = length;
        end
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // n bytes total: n-4 data bytes then the FCS, least significant byte first
    task automatic build_frame(input int n, input int seed);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            frm[i] = 8'((i * 7 + seed) & 255);
            c = crc_step(c, frm[i]);
        end
        c = ~c;
        for (int j = 0; j < 4; j++) frm[n - 4 + j] = c[8*j +: 8];
        frm_len = n;
    endtask

    task automatic send_frame(input int npre, input int er_idx);
        for (int i = 0; i < npre; i++) begin
            @(negedge rx_clk); rx_dv = 1'b1; rx_er = 1'b0; rx_data = 8'h55;
        end
        @(negedge rx_clk); rx_data = 8'hD5;
        for (int i = 0; i < frm_len; i++) begin
            @(negedge rx_clk); rx_data = frm[i]; rx_er = (i == er_idx);
        end
        @(negedge rx_clk); rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge rx_clk); rx_dv = 1'b0; rx_er = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge rx_clk);
        #1;
        checks++;
        if ({out_valid, out_sop, out_data, done, ok, crc_bad, runt, giant, phy_err, length} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {out_valid, out_sop, out_data, done, ok, crc_bad, runt, giant, phy_err, length});
        end
        @(negedge rx_clk); rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_good;
        int base, bad, nsop;
        build_frame(64, 3);
        got.delete(); got_sop.delete(); base = done_cnt;
        send_frame(7, -1);
        idle(3);
        checks++;
        if (got.size() !== 60) begin errors++; $display("FAIL good_count got %0d want 60", got.size()); end
        bad = 0; nsop = 0;
        for (int i = 0; i < got.size() && i < 60; i++) begin
            if (got[i] !== frm[i]) bad++;
            if (got_sop[i]) nsop++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL good_data mismatching bytes %0d want 0", bad); end
        checks++;
        if (got.size() == 0 || got_sop[0] !== 1'b1 || nsop !== 1) begin
            errors++; $display("FAIL good_sop sop count %0d want 1 on first byte", nsop);
        end
        checks++;
        if (done_cnt - base !== 1) begin errors++; $display("FAIL good_done got %0d want 1", done_cnt - base); end
        checks++;
        if ({l_ok, l_crc_bad, l_runt, l_giant, l_phy} !== 5'b10000 || l_len !== 11'd64) begin
            errors++; $display("FAIL good_status flags %b len %0d want 10000 len 64",
                               {l_ok, l_crc_bad, l_runt, l_giant, l_phy}, l_len);
        end
    endtask

    task automatic test_crc_bad;
        int base;
        build_frame(64, 3);
        frm[34] = frm[34] ^ 8'h01;
        got.delete(); got_sop.delete(); base = done_cnt;
        send_frame(7, -1);
        idle(3);
        checks++;
        if (got.size() !== 60 || got[34] !== frm[34]) begin
            errors++; $display("FAIL crcbad_data count %0d want 60", got.size());
        end
        checks++;
        if (done_cnt - base !== 1 || {l_ok, l_crc_bad, l_runt, l_giant, l_phy} !== 5'b01000) begin
            errors++; $display("FAIL crcbad_status done %0d flags %b want 1 01000",
                               done_cnt - base, {l_ok, l_crc_bad, l_runt, l_giant, l_phy});
        end
    endtask

    task automatic test_phy_err;
        int base;
        build_frame(64, 9);
        got.delete(); got_sop.delete(); base = done_cnt;
        send_frame(7, 29);
        idle(3);
        checks++;
        if (got.size() !== 25) begin errors++; $display("FAIL phyerr_count got %0d want 25", got.size()); end
        checks++;
        if (done_cnt - base !== 1 || l_phy !== 1'b1 || l_crc_bad !== 1'b0 || l_ok !== 1'b0) begin
            errors++; $display("FAIL phyerr_status done %0d phy %b crc_bad %b ok %b want 1 1 0 0",
                               done_cnt - base, l_phy, l_crc_bad, l_ok);
        end
    endtask

    task automatic test_length;
        int base;
        build_frame(40, 11);
        got.delete(); got_sop.delete(); base = done_cnt;
        send_frame(7, -1);
        idle(3);
        checks++;
        if (got.size() !== 36) begin errors++; $display("FAIL runt_count got %0d want 36", got.size()); end
        checks++;
        if (done_cnt - base !== 1 || {l_ok, l_crc_bad, l_runt, l_giant, l_phy} !== 5'b00100 || l_len !== 11'd40) begin
            errors++; $display("FAIL runt_status flags %b len %0d want 00100 len 40",
                               {l_ok, l_crc_bad, l_runt, l_giant, l_phy}, l_len);
        end
        build_frame(1519, 1);
        got.delete(); got_sop.delete(); base = done_cnt;
        send_frame(7, -1);
        idle(3);
        checks++;
        if (got.size() !== 1514) begin errors++; $display("FAIL giant_count got %0d want 1514", got.size()); end
        checks++;
        if (done_cnt - base !== 1 || {l_ok, l_crc_bad, l_runt, l_giant, l_phy} !== 5'b00010 || l_len !== 11'd1519) begin
            errors++; $display("FAIL giant_status flags %b len %0d want 00010 len 1519",
                               {l_ok, l_crc_bad, l_runt, l_giant, l_phy}, l_len);
        end
    endtask

    task automatic test_bad_preamble;
        int base;
        got.delete(); got_sop.delete(); base = done_cnt;
        @(negedge rx_clk); rx_dv = 1'b1; rx_data = 8'h55;
        @(negedge rx_clk); rx_data = 8'h55;
        @(negedge rx_clk); rx_data = 8'h12;
        for (int i = 0; i < 10; i++) begin
            @(negedge rx_clk); rx_data = 8'((i * 13 + 1) & 255);
        end
        idle(12);
        checks++;
        if (got.size() !== 0 || done_cnt !== base) begin
            errors++; $display("FAIL badpre_quiet bytes %0d done %0d want 0 0", got.size(), done_cnt - base);
        end
        build_frame(64, 17);
        send_frame(7, -1);
        idle(3);
        checks++;
        if (done_cnt - base !== 1 || l_ok !== 1'b1 || got.size() !== 60) begin
            errors++; $display("FAIL badpre_next done %0d ok %b bytes %0d want 1 1 60",
                               done_cnt - base, l_ok, got.size());
        end
    endtask

    task automatic test_back_to_back;
        int base, okb;
        build_frame(64, 21);
        got.delete(); got_sop.delete(); base = done_cnt; okb = ok_cnt;
        send_frame(7, -1);
        send_frame(2, -1);
        idle(3);
        checks++;
        if (done_cnt - base !== 2 || ok_cnt - okb !== 2 || got.size() !== 120) begin
            errors++; $display("FAIL b2b done %0d ok %0d bytes %0d want 2 2 120",
                               done_cnt - base, ok_cnt - okb, got.size());
        end
    endtask

    task automatic test_reset_mid_frame;
        int base;
        build_frame(64, 5);
        base = done_cnt;
        for (int i = 0; i < 7; i++) begin
            @(negedge rx_clk); rx_dv = 1'b1; rx_er = 1'b0; rx_data = 8'h55;
        end
        @(negedge rx_clk); rx_data = 8'hD5;
        for (int i = 0; i < 40; i++) begin
            @(negedge rx_clk); rx_data = frm[i];
        end
        @(negedge rx_clk); rx_data = frm[40]; rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sop, out_data, done, ok, crc_bad, runt, giant, phy_err, length} !== 27'd0) begin
            errors++; $display("FAIL midreset_outputs got %h want 0",
                               {out_valid, out_sop, out_data, done, ok, crc_bad, runt, giant, phy_err, length});
        end
        got.delete(); got_sop.delete();
        @(negedge rx_clk); rx_data = frm[41];
        @(negedge rx_clk); rx_data = frm[42];
        @(negedge rx_clk); rx_data = frm[43]; rst_n = 1'b1;
        for (int i = 44; i < frm_len; i++) begin
            @(negedge rx_clk); rx_data = frm[i];
        end
        idle(4);
        checks++;
        if (got.size() !== 0 || done_cnt !== base) begin
            errors++; $display("FAIL midreset_tail bytes %0d done %0d want 0 0", got.size(), done_cnt - base);
        end
        build_frame(64, 29);
        send_frame(7, -1);
        idle(3);
        checks++;
        if (done_cnt - base !== 1 || l_ok !== 1'b1 || l_len !== 11'd64 || got.size() !== 60) begin
            errors++; $display("FAIL midreset_next done %0d ok %b len %0d bytes %0d want 1 1 64 60",
                               done_cnt - base, l_ok, l_len, got.size());
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_crc_bad();
        test_phy_err();
        test_length();
        test_bad_preamble();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
